conv_pass_sequencer: RTL and testbench

- Top-level pass controller for the convolution datapath. It drives IF/filter buffer loads, read-address generation, psum register clears and filter rewinds.
- Generalises the fixed-mode design controller to a parametrised number of filter-row passes, with a done/busy handshake, optional auto-repeat and saturating mode decode.
- Sits between the host start/mode interface and the IF buffer, filter buffer, read-address generator and PE psum registers.

---
 rtl/conv_pass_sequencer.sv | 141 ++++++++++++++
 tb/tb_conv_pass_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_pass_sequencer.sv
// Pass controller for the convolution datapath: sequences buffer loads, read-address
// launch, psum clears and per-row filter rewinds for full, add-only and multi-row jobs.
module conv_pass_sequencer #(
  parameter int MAX_ROWS = 4,
  parameter int MODE_W   = 2,
  parameter int ROW_W    = $clog2(MAX_ROWS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MODE_W-1:0] mode,
  input  logic              just_add_flag,
  input  logic              repeat_en,
  input  logic              full_done,
  input  logic              psum_done,
  input  logic              stride_count_flag,
  input  logic              stride_pos_ld,
  output logic              reset_all,
  output logic              if_read_start,
  output logic              filter_read_start,
  output logic              start_rd_gen,
  output logic              clear_regs,
  output logic              usage_stride_pos_ld,
  output logic              reset_filter,
  output logic [ROW_W-1:0]  row_idx,
  output logic              busy,
  output logic              done
);

  // state    | meaning
  // IDLE     | waiting for start, datapath held in reset
  // LOAD     | IF/filter buffers loading while start is held
  // DISPATCH | launch read-address generator, latch job settings
  // FULL     | full pass running until full_done
  // ADD      | accumulate-only pass running until full_done
  // PRIME    | waiting for first stride_pos_ld of a row job
  // ROW      | row passes, filter rewound between rows
  // DONE     | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DISPATCH, S_FULL, S_ADD, S_PRIME, S_ROW, S_DONE
  } state_t;

  localparam int CW = (MODE_W > ROW_W) ? MODE_W : ROW_W;
  localparam logic [ROW_W-1:0] ONE = ROW_W'(1);

  state_t           state;
  logic [ROW_W-1:0] row_cnt;
  logic [ROW_W-1:0] eff_mode;
  logic             add_lat;

  logic [CW-1:0]    mode_ext;
  logic [ROW_W-1:0] mode_sat;
  logic             last_row;
  logic             clr_evt;

  assign mode_ext = CW'(mode);
  assign mode_sat = (mode_ext > CW'(MAX_ROWS)) ? ROW_W'(MAX_ROWS) : ROW_W'(mode_ext);
  assign last_row = (row_cnt >= eff_mode - ONE);
  assign clr_evt  = psum_done | stride_count_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      row_cnt  <= '0;
      eff_mode <= '0;
      add_lat  <= 1'b0;
    end else if (start) begin
      state   <= S_LOAD;
      row_cnt <= '0;
    end else begin
      case (state)
        S_IDLE:  state <= S_IDLE;
        S_LOAD:  state <= S_DISPATCH;
        S_DISPATCH: begin
          add_lat  <= just_add_flag;
          eff_mode <= mode_sat;
          if (just_add_flag)    state <= S_ADD;
          else if (mode == '0)  state <= S_FULL;
          else                  state <= S_PRIME;
        end
        S_FULL, S_ADD: begin
          if (full_done) state <= repeat_en ? S_DISPATCH : S_DONE;
        end
        S_PRIME: begin
          if (stride_pos_ld) begin
            state   <= S_ROW;
            row_cnt <= '0;
          end
        end
        S_ROW: begin
          if (stride_pos_ld) begin
            if (last_row) state <= S_DONE;
            else          row_cnt <= row_cnt + ONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    reset_all           = start;
    if_read_start       = 1'b0;
    filter_read_start   = 1'b0;
    start_rd_gen        = 1'b0;
    clear_regs          = 1'b0;
    usage_stride_pos_ld = 1'b1;
    reset_filter        = 1'b0;
    row_idx             = '0;
    busy                = 1'b1;
    done                = 1'b0;
    case (state)
      S_IDLE: begin
        reset_all = 1'b1;
        busy      = 1'b0;
      end
      S_LOAD: begin
        if_read_start     = 1'b1;
        filter_read_start = 1'b1;
      end
      S_DISPATCH: start_rd_gen = 1'b1;
      // add jobs accumulate onto existing psums, so they never clear
      S_FULL:  clear_regs = clr_evt & ~add_lat;
      S_ADD:   clear_regs = 1'b0;
      S_PRIME: clear_regs = clr_evt;
      S_ROW: begin
        clear_regs          = clr_evt;
        usage_stride_pos_ld = 1'b0;
        row_idx             = row_cnt;
        reset_filter        = stride_pos_ld & ~last_row;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_conv_pass_sequencer.sv
// Randomised scoreboard bench: two sequencers (MAX_ROWS 4 and 2) share stimulus and are
// checked every cycle against a job-level reference model.
module tb_conv_pass_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, just_add_flag, repeat_en;
  logic       full_done, psum_done, stride_count_flag, stride_pos_ld;
  logic [1:0] mode;

  logic       a_ra, a_ifr, a_fr, a_srg, a_clr, a_usp, a_rf, a_busy, a_done;
  logic [2:0] a_row;
  logic       b_ra, b_ifr, b_fr, b_srg, b_clr, b_usp, b_rf, b_busy, b_done;
  logic [1:0] b_row;

  conv_pass_sequencer #(.MAX_ROWS(4), .MODE_W(2)) dut4 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .just_add_flag(just_add_flag),
    .repeat_en(repeat_en), .full_done(full_done), .psum_done(psum_done),
    .stride_count_flag(stride_count_flag), .stride_pos_ld(stride_pos_ld),
    .reset_all(a_ra), .if_read_start(a_ifr), .filter_read_start(a_fr),
    .start_rd_gen(a_srg), .clear_regs(a_clr), .usage_stride_pos_ld(a_usp),
    .reset_filter(a_rf), .row_idx(a_row), .busy(a_busy), .done(a_done));

  conv_pass_sequencer #(.MAX_ROWS(2), .MODE_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .just_add_flag(just_add_flag),
    .repeat_en(repeat_en), .full_done(full_done), .psum_done(psum_done),
    .stride_count_flag(stride_count_flag), .stride_pos_ld(stride_pos_ld),
    .reset_all(b_ra), .if_read_start(b_ifr), .filter_read_start(b_fr),
    .start_rd_gen(b_srg), .clear_regs(b_clr), .usage_stride_pos_ld(b_usp),
    .reset_filter(b_rf), .row_idx(b_row), .busy(b_busy), .done(b_done));

  typedef struct {
    int          cyc;
    logic [12:0] e0;
    logic [12:0] e1;
  } exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // job phases of the reference model
  localparam int P_IDLE = 0, P_LOAD = 1, P_DISP = 2, P_FULL = 3;
  localparam int P_ADD  = 4, P_PRIME = 5, P_ROW = 6, P_DONE = 7;
  int ph[2], cnt[2], eff[2];
  int maxr[2] = '{4, 2};

  logic [1:0] j_mode;
  logic       j_add, j_rep;

  // output vector: {reset_all, if_rd, filt_rd, rd_gen, clear, usage_ld, rst_filt, busy, done, row[3:0]}
  function automatic logic [12:0] expect_out(int k);
    logic [12:0] v;
    int          p;
    logic        ev;
    p  = ph[k];
    ev = psum_done | stride_count_flag;
    v[12]  = start || (p == P_IDLE);
    v[11]  = (p == P_LOAD);
    v[10]  = (p == P_LOAD);
    v[9]   = (p == P_DISP);
    v[8]   = ev && (p == P_FULL || p == P_PRIME || p == P_ROW);
    v[7]   = (p != P_ROW);
    v[6]   = (p == P_ROW) && stride_pos_ld && (cnt[k] + 1 < eff[k]);
    v[5]   = (p != P_IDLE) && (p != P_DONE);
    v[4]   = (p == P_DONE);
    v[3:0] = (p == P_ROW) ? 4'(cnt[k]) : 4'd0;
    return v;
  endfunction

  function automatic void advance();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ph[k] = P_IDLE; cnt[k] = 0; eff[k] = 0;
      end else if (start) begin
        ph[k] = P_LOAD; cnt[k] = 0;
      end else begin
        case (ph[k])
          P_LOAD: ph[k] = P_DISP;
          P_DISP: begin
            eff[k] = (int'(mode) > maxr[k]) ? maxr[k] : int'(mode);
            if (just_add_flag)   ph[k] = P_ADD;
            else if (mode == 0)  ph[k] = P_FULL;
            else                 ph[k] = P_PRIME;
          end
          P_FULL, P_ADD: if (full_done) ph[k] = repeat_en ? P_DISP : P_DONE;
          P_PRIME: if (stride_pos_ld) begin ph[k] = P_ROW; cnt[k] = 0; end
          P_ROW: if (stride_pos_ld) begin
            if (cnt[k] + 1 < eff[k]) cnt[k]++;
            else ph[k] = P_DONE;
          end
          P_DONE: ph[k] = P_IDLE;
          default: ph[k] = P_IDLE;
        endcase
      end
    end
  endfunction

  task automatic drive(input logic r, input logic s, input logic fd, input logic pd,
                       input logic sc, input logic spl, input bit chk);
    @(negedge clk);
    rst = r; start = s; full_done = fd; psum_done = pd; stride_count_flag = sc;
    stride_pos_ld = spl; mode = j_mode; just_add_flag = j_add; repeat_en = j_rep;
    #1;
    if (chk) q.push_back('{cyc, expect_out(0), expect_out(1)});
    @(posedge clk);
    advance();
    cyc++;
  endtask

  task automatic tick(input logic s, input logic fd, input logic pd, input logic spl);
    drive(1'b0, s, fd, pd, 1'b0, spl, 1'b1);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [12:0] g0, g1;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e  = q.pop_front();
        g0 = {a_ra, a_ifr, a_fr, a_srg, a_clr, a_usp, a_rf, a_busy, a_done, 4'(a_row)};
        g1 = {b_ra, b_ifr, b_fr, b_srg, b_clr, b_usp, b_rf, b_busy, b_done, 4'(b_row)};
        n_vec++;
        if (g0 !== e.e0 || g1 !== e.e1) begin
          n_err++;
          $display("FAIL outputs cycle %0d: max4 got %b want %b, max2 got %b want %b",
                   e.cyc, g0, e.e0, g1, e.e1);
        end
      end
    end
  end

  initial begin : stim
    j_mode = 2'd0; j_add = 1'b0; j_rep = 1'b0;
    foreach (ph[k]) begin ph[k] = P_IDLE; cnt[k] = 0; eff[k] = 0; end

    // reset, then idle
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) tick(0, 0, 0, 0);

    // full job
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(0, 1, 1, 0);
    repeat (2) tick(0, 0, 0, 0);

    // three-row job; the MAX_ROWS=2 instance saturates to two rows
    j_mode = 2'd3;
    tick(1, 0, 0, 0);
    repeat (2) tick(0, 0, 0, 0);
    repeat (4) begin
      tick(0, 0, 0, 1);
      tick(0, 0, 1, 0);
    end
    repeat (2) tick(0, 0, 0, 0);

    // add-only job with auto-repeat, then finished with repeat off
    j_mode = 2'd2; j_add = 1'b1; j_rep = 1'b1;
    tick(1, 0, 0, 0);
    repeat (2) tick(0, 0, 1, 0);
    tick(0, 1, 0, 0);
    repeat (2) tick(0, 0, 0, 0);
    j_rep = 1'b0;
    tick(0, 1, 0, 0);
    repeat (2) tick(0, 0, 0, 0);

    // restart in ROW coinciding with stride_pos_ld
    j_mode = 2'd3; j_add = 1'b0;
    tick(1, 0, 0, 0);
    repeat (2) tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(1, 0, 0, 1);
    repeat (3) tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) tick(0, 0, 0, 0);

    // randomised traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        j_mode = 2'($urandom_range(0, 3));
        j_add  = ($urandom_range(0, 3) == 0);
        j_rep  = ($urandom_range(0, 3) == 0);
      end
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, 1'b1);
    end

    @(negedge clk);
    #5;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
